mem_read_arbiter_rr: RTL and testbench
======================================

# mem_read_arbiter_rr

Registered N-port arbiter for the shared instruction-memory read port, the parametrised successor to the fixed two-input memory arbiter used in the single-engine topology. It collects read requests from `N_PORTS` clients (port 0 is the control-channel client, ports 1..N_PORTS-1 are engines) and issues one request at a time to memory. Read data is broadcast to all clients, and the ready pulse is routed only to the winner. It sits between the engine array and the memory port in multi-engine topologies.

## Interface
- `N_PORTS`, default 4: number of requesting clients, ≥2, any integer (not restricted to a power of 2).
- `MEMORY_ADDR_WIDTH`, default 11: address width.
- `MEMORY_WIDTH`, default 20: data width.
- `ID_W`, default `$clog2(N_PORTS)`, minimum 1: width of the grant index. Derived; not to be overridden.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in N_PORTS: per-client request.
- `in_addr` in N_PORTS*MEMORY_ADDR_WIDTH: per-client address; port i occupies bits [i*W +: W].
- `in_ready` out N_PORTS: one-hot completion pulse to the winner.
- `in_data` out MEMORY_WIDTH: broadcast read data (= `mem_data`).
- `mem_valid` out 1: request to memory.
- `mem_addr` out MEMORY_ADDR_WIDTH: address to memory.
- `mem_ready` in 1: memory has completed the read; `mem_data` is valid in the same cycle.
- `mem_data` in MEMORY_WIDTH: memory read data.
- `busy` out 1: high while the FSM is in ISSUE.
- `grant_id` out ID_W: index of the current or last winner.

## Operation
- FSM states: IDLE, ISSUE.
- **IDLE, no `in_valid` set:** stay in IDLE.
- **IDLE, any `in_valid` set:**
  - Select the winner by round-robin, searching upward from `ptr` with wrap at N_PORTS.
  - Register the winner into `grant_id`.
  - Go to ISSUE.
- **ISSUE:**
  - `mem_valid = in_valid[grant_id]`.
  - `mem_addr = in_addr[grant_id]` (combinational pass-through).
  - `in_ready[grant_id] = mem_ready & in_valid[grant_id]`; all other `in_ready` bits are 0.
- **ISSUE, completion (`mem_ready & in_valid[grant_id]`):**
  - `ptr <= (grant_id == N_PORTS-1) ? 0 : grant_id+1`.
  - Go to IDLE.
- **ISSUE, withdrawal (`in_valid[grant_id]` = 0):**
  - Go to IDLE; `ptr` is unchanged.
  - `mem_valid` is already 0 in that cycle, so memory sees no request.
- **Client rule:** hold `in_valid` and `in_addr` stable until `in_ready`.
- **Data path:** `in_data` always equals `mem_data`. Clients qualify it with their own `in_ready`.
- **Ignored inputs:** `mem_ready` in IDLE is ignored. Requests from non-granted ports are ignored during ISSUE.

## Timing
- **Reset values:**
  - State IDLE, `ptr = 0`, `grant_id = 0`.
  - `busy = 0`, `mem_valid = 0`, `in_ready = 0`.
  - `mem_addr` = `in_addr` of port 0 (don't-care).
- **Arbitration latency:** a request seen in IDLE at edge k gives `mem_valid` high in cycle k+1.
- **Completion timing:** `in_ready` is asserted in the same cycle as `mem_ready`.
- **Throughput:** at most one grant every 2 cycles; a mandatory IDLE bubble follows each completion.
- **Reset mid-ISSUE:** `mem_valid` and `in_ready` drop asynchronously. The aborted request is not acknowledged, and the client must re-request.
- **Simultaneous events:** a client raising `in_valid` in the completion cycle is considered in the next IDLE cycle.
- **Wrap:** N_PORTS=3 with `grant_id=2` makes `ptr=0`. Grant-index arithmetic never produces index ≥ N_PORTS.

## Configuration
- **`MEM_ARB_PRIORITY0_EN` defined:**
  - In IDLE, `in_valid[0]` wins unconditionally (control-channel priority, matching single-engine behaviour).
  - A port-0 grant does not update `ptr`.
  - Ports 1..N-1 round-robin among themselves when port 0 is idle.
- **Not defined:** all ports are in one round-robin ring, including port 0.

## Test plan
- **Single request:** port 2 requests addr 0x155; memory returns ready on the 1st ISSUE cycle with data 0xABCDE -> `mem_valid` in cycle k+1, `mem_addr = 0x155`, `in_ready = 4'b0100` for one cycle, `in_data = 0xABCDE`, `ptr = 3`.
- **Full contention, no macro:** N=4, all ports hold `in_valid` and memory is always ready -> grant order 0,1,2,3,0,1. Each grant is 2 cycles apart, and `in_ready` is one-hot each time.
- **Priority, macro on:** all ports request continuously -> port 0 wins every grant and `ptr` stays at 0. Drop port 0 -> order 1,2,3,1.
- **Withdrawal:** port 1 is granted, then drops `in_valid` before `mem_ready` -> `mem_valid` = 0 in that cycle, no `in_ready`, FSM returns to IDLE, `ptr` unchanged.
- **Reset mid-ISSUE:** assert `rst` low while in ISSUE with port 3 granted -> outputs reach their reset values immediately. After release, port 0 wins if all ports request.
- **Wrap:** N=3, ports 0 and 2 request continuously -> grants 0,2,0,2, and `grant_id` never exceeds 2.

Source files
------------

// File: rtl/mem_read_arbiter_rr.sv
// Registered N-port round-robin arbiter for the shared instruction-memory read port.
// Define MEM_ARB_PRIORITY0_EN to give port 0 (control channel) absolute priority in IDLE.
module mem_read_arbiter_rr #(
  parameter int unsigned N_PORTS           = 4,
  parameter int unsigned MEMORY_ADDR_WIDTH = 11,
  parameter int unsigned MEMORY_WIDTH      = 20,
  parameter int unsigned ID_W              = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_PORTS-1:0]                   in_valid,
  input  logic [N_PORTS*MEMORY_ADDR_WIDTH-1:0] in_addr,
  output logic [N_PORTS-1:0]                   in_ready,
  output logic [MEMORY_WIDTH-1:0]              in_data,
  output logic                                 mem_valid,
  output logic [MEMORY_ADDR_WIDTH-1:0]         mem_addr,
  input  logic                                 mem_ready,
  input  logic [MEMORY_WIDTH-1:0]              mem_data,
  output logic                                 busy,
  output logic [ID_W-1:0]                      grant_id
);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  localparam logic [ID_W-1:0] LastId = ID_W'(N_PORTS - 1);

  state_e          state_q;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] grant_q;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] ptr_next;
  logic            found;
  logic            gnt_valid;
  int unsigned     idx;

  // Search upward from ptr_q, wrapping at N_PORTS; first requester wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (!found && in_valid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
`ifdef MEM_ARB_PRIORITY0_EN
    if (in_valid[0]) winner = '0;
`endif
  end

  assign ptr_next  = (grant_q == LastId) ? '0 : grant_q + 1'b1;
  assign gnt_valid = in_valid[grant_q];
  assign busy      = (state_q == StIssue);
  assign grant_id  = grant_q;
  assign in_data   = mem_data;
  assign mem_valid = busy & gnt_valid;
  assign mem_addr  = in_addr[32'(grant_q)*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];

  always_comb begin
    in_ready = '0;
    if (busy) in_ready[grant_q] = mem_ready & gnt_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|in_valid) begin
            grant_q <= winner;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (!gnt_valid) begin
            // Client withdrew: drop back without advancing the ring.
            state_q <= StIdle;
          end else if (mem_ready) begin
            state_q <= StIdle;
`ifdef MEM_ARB_PRIORITY0_EN
            if (grant_q != '0) ptr_q <= ptr_next;
`else
            ptr_q <= ptr_next;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter_rr.sv
// Table-driven bench for mem_read_arbiter_rr: N=4 instance plus an N=3 instance for wrap.
module tb_mem_read_arbiter_rr;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  // N=4 instance
  logic [3:0]  in_valid;
  logic [43:0] in_addr;
  logic [3:0]  in_ready;
  logic [19:0] in_data;
  logic        mem_valid;
  logic [10:0] mem_addr;
  logic        mem_ready;
  logic [19:0] mem_data;
  logic        busy;
  logic [1:0]  grant_id;

  mem_read_arbiter_rr #(.N_PORTS(4), .MEMORY_ADDR_WIDTH(11), .MEMORY_WIDTH(20)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_ready(in_ready),
    .in_data(in_data), .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_data(mem_data), .busy(busy), .grant_id(grant_id)
  );

  // N=3 instance, memory always ready
  logic [2:0]  w_valid;
  logic [32:0] w_addr;
  logic [2:0]  w_ready;
  logic [19:0] w_data;
  logic        w_mem_valid;
  logic [10:0] w_mem_addr;
  logic        w_mem_ready;
  logic [19:0] w_mem_data;
  logic        w_busy;
  logic [1:0]  w_grant;

  mem_read_arbiter_rr #(.N_PORTS(3), .MEMORY_ADDR_WIDTH(11), .MEMORY_WIDTH(20)) dut3 (
    .clk(clk), .rst(rst), .in_valid(w_valid), .in_addr(w_addr), .in_ready(w_ready),
    .in_data(w_data), .mem_valid(w_mem_valid), .mem_addr(w_mem_addr),
    .mem_ready(w_mem_ready), .mem_data(w_mem_data), .busy(w_busy), .grant_id(w_grant)
  );

  typedef struct {
    logic [3:0]  valid;
    int          delay;
    logic [19:0] data;
    int          exp_grant;
    int          exp_ptr;
  } vec_t;

  vec_t        vecs[10];
  int          n_vec;
  logic [10:0] addr_tbl[4];
  int          wrap_exp[4];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    addr_tbl[0] = 11'h0A0;
    addr_tbl[1] = 11'h1B1;
    addr_tbl[2] = 11'h155;
    addr_tbl[3] = 11'h3C3;
    in_addr     = {addr_tbl[3], addr_tbl[2], addr_tbl[1], addr_tbl[0]};
    w_addr      = {11'h222, 11'h111, 11'h000};
    in_valid    = '0;
    w_valid     = '0;
    mem_ready   = 1'b0;
    w_mem_ready = 1'b1;
    mem_data    = '0;
    w_mem_data  = 20'h12345;

`ifdef MEM_ARB_PRIORITY0_EN
    n_vec   = 10;
    vecs[0] = '{4'b1111, 0, 20'h00001, 0, 0};
    vecs[1] = '{4'b1111, 0, 20'h00002, 0, 0};
    vecs[2] = '{4'b1111, 1, 20'h00003, 0, 0};
    vecs[3] = '{4'b1110, 0, 20'h00004, 1, 2};
    vecs[4] = '{4'b1110, 0, 20'h00005, 2, 3};
    vecs[5] = '{4'b1110, 0, 20'h00006, 3, 0};
    vecs[6] = '{4'b1110, 0, 20'h00007, 1, 2};
    vecs[7] = '{4'b0100, 0, 20'hABCDE, 2, 3};
    vecs[8] = '{4'b0011, 2, 20'h00009, 0, 3};
    vecs[9] = '{4'b0010, 0, 20'h0000A, 1, 2};
    wrap_exp = '{0, 0, 0, 0};
`else
    n_vec   = 10;
    vecs[0] = '{4'b1111, 0, 20'h00001, 0, 1};
    vecs[1] = '{4'b1111, 0, 20'h00002, 1, 2};
    vecs[2] = '{4'b1111, 1, 20'h00003, 2, 3};
    vecs[3] = '{4'b1111, 0, 20'h00004, 3, 0};
    vecs[4] = '{4'b1111, 0, 20'h00005, 0, 1};
    vecs[5] = '{4'b1111, 0, 20'h00006, 1, 2};
    vecs[6] = '{4'b0100, 0, 20'hABCDE, 2, 3};
    vecs[7] = '{4'b0011, 2, 20'h00008, 0, 1};
    vecs[8] = '{4'b1001, 0, 20'h00009, 3, 0};
    vecs[9] = '{4'b0010, 0, 20'h0000A, 1, 2};
    wrap_exp = '{0, 2, 0, 2};
`endif

    // Reset values
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_valid", 32'(mem_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_mem_addr", 32'(mem_addr), 32'(addr_tbl[0]));
    @(posedge clk); #1;
    rst = 1'b1;

    for (int v = 0; v < n_vec; v++) begin
      in_valid  = vecs[v].valid;
      mem_ready = 1'b0;
      #1;
      chk($sformatf("v%0d_idle_mem_valid", v), 32'(mem_valid), 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_busy", v), 32'(busy), 1);
      chk($sformatf("v%0d_grant", v), 32'(grant_id), 32'(vecs[v].exp_grant));
      chk($sformatf("v%0d_mem_valid", v), 32'(mem_valid), 1);
      chk($sformatf("v%0d_mem_addr", v), 32'(mem_addr), 32'(addr_tbl[vecs[v].exp_grant]));
      chk($sformatf("v%0d_no_ready", v), 32'(in_ready), 0);
      for (int d = 0; d < vecs[v].delay; d++) begin
        @(posedge clk); #1;
        chk($sformatf("v%0d_wait_busy", v), 32'(busy), 1);
        chk($sformatf("v%0d_wait_ready", v), 32'(in_ready), 0);
      end
      mem_ready = 1'b1;
      mem_data  = vecs[v].data;
      #1;
      chk($sformatf("v%0d_in_ready", v), 32'(in_ready), 32'(1) << vecs[v].exp_grant);
      chk($sformatf("v%0d_in_data", v), 32'(in_data), 32'(vecs[v].data));
      @(posedge clk); #1;
      chk($sformatf("v%0d_bubble", v), 32'(busy), 0);
      chk($sformatf("v%0d_bubble_ready", v), 32'(in_ready), 0);
      chk($sformatf("v%0d_ptr", v), 32'(dut.ptr_q), 32'(vecs[v].exp_ptr));
    end
    in_valid  = '0;
    mem_ready = 1'b0;

    // Withdrawal: port 1 granted then drops before completion; ptr stays at 2
    @(posedge clk); #1;
    in_valid = 4'b0010;
    @(posedge clk); #1;
    chk("wd_grant", 32'(grant_id), 1);
    chk("wd_busy", 32'(busy), 1);
    in_valid  = 4'b0000;
    mem_ready = 1'b1;
    #1;
    chk("wd_mem_valid", 32'(mem_valid), 0);
    chk("wd_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("wd_idle", 32'(busy), 0);
    chk("wd_ptr", 32'(dut.ptr_q), 2);
    mem_ready = 1'b0;

    // Reset during ISSUE with port 3 granted
    in_valid = 4'b1000;
    @(posedge clk); #1;
    chk("rm_grant", 32'(grant_id), 3);
    chk("rm_mem_valid", 32'(mem_valid), 1);
    rst       = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("rm_busy", 32'(busy), 0);
    chk("rm_mem_valid0", 32'(mem_valid), 0);
    chk("rm_in_ready0", 32'(in_ready), 0);
    chk("rm_grant0", 32'(grant_id), 0);
    chk("rm_ptr0", 32'(dut.ptr_q), 0);
    @(posedge clk); #1;
    rst       = 1'b1;
    mem_ready = 1'b0;
    in_valid  = 4'b1111;
    @(posedge clk); #1;
    chk("rm_regrant", 32'(grant_id), 0);
    chk("rm_rebusy", 32'(busy), 1);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = '0;
    mem_ready = 1'b0;

    // Wrap on N=3: ports 0 and 2 hold requests continuously
    w_valid = 3'b101;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("wrap%0d_busy", k), 32'(w_busy), 1);
      chk($sformatf("wrap%0d_grant", k), 32'(w_grant), 32'(wrap_exp[k]));
      chk($sformatf("wrap%0d_ready", k), 32'(w_ready), 32'(1) << wrap_exp[k]);
      chk($sformatf("wrap%0d_in_range", k), 32'(w_grant <= 2'd2), 1);
      @(posedge clk); #1;
      chk($sformatf("wrap%0d_bubble", k), 32'(w_busy), 0);
    end
    chk("wrap_ptr", 32'(dut3.ptr_q), 0);
    w_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
